pipelined_barrel_shifter: RTL and testbench
===========================================

// Module: pipelined_barrel_shifter
// PURPOSE
//  Parametrised, pipelined shifter for the execute stage: SLL/SRL/SRA (plus optional ROL/ROR) over WIDTH bits.
//  Log-structured shift levels (WIDTH/2, ..., 2, 1) split across PIPE_STAGES register boundaries.
//  Valid/ready handshake with backpressure; a tag travels alongside each operand so writeback knows its rd.
//  Pipeline flush supports branch-mispredict squash.
// PARAMETERS
//  WIDTH        32  data width; power of two, >= 8
//  SHAMT_W      $clog2(WIDTH)  shift-amount width (derived, not overridden)
//  PIPE_STAGES  2   register boundaries, 1..SHAMT_W; latency in cycles
//  TAG_W        5   width of pass-through tag (destination register)
// PORTS
//  clock       in   1        rising-edge clock
//  reset       in   1        synchronous, active-high
//  flush       in   1        synchronous squash of all in-flight ops
//  in_valid    in   1        operand valid
//  in_ready    out  1        block can accept this cycle
//  in_data     in   WIDTH    operand A
//  in_shamt    in   SHAMT_W  shift amount
//  in_mode     in   2        shifter_pkg::shift_mode_t
//  in_tag      in   TAG_W    pass-through tag
//  out_valid   out  1        result valid
//  out_ready   in   1        consumer accepts
//  out_data    out  WIDTH    shifted result
//  out_tag     out  TAG_W    tag of out_data
//  out_illegal out  1        mode unsupported in this build (qualified by out_valid)
// BEHAVIOUR
//  - Reset: all stage valids 0; out_valid=0, out_data=0, out_tag=0, out_illegal=0; in_ready=1 the cycle after.
//  - Transfer occurs on valid&&ready at each side; latency exactly PIPE_STAGES cycles with no stall.
//  - Stage k loads when empty or its contents move on same cycle: ready_k = !valid_k || ready_{k+1}.
//    in_ready = ready_0; full throughput (1 op/cycle) with out_ready held 1; no bubbles inserted.
//  - Stall: out_valid && !out_ready holds out_data/out_tag/out_illegal stable; upstream fills, then in_ready=0.
//  - Levels per stage: ceil(SHAMT_W/PIPE_STAGES), largest shift first; last stage takes remainder.
//  - Modes: 00 SLL zero-fill; 01 SRL zero-fill; 10 SRA sign-fill from in_data[WIDTH-1]; 11 rotate (see CONFIG).
//  - SRL/SRA implemented as bit-reverse -> left shift -> bit-reverse; sign bit and mode carried with the data.
//  - shamt=0 passes data unchanged in every mode; max shamt = WIDTH-1; no mod beyond SHAMT_W bits.
//  - flush: clears all stage valids next edge; in_valid in the flush cycle is dropped; flush wins over reset-free
//    accepts; reset wins over flush. out_valid=0 cycle after flush; data regs need not clear.
//  - Reset mid-operation: all in-flight ops lost, no partial result emitted.
// CONFIGURATION
//  SHIFTER_ROTATE_EN defined: mode 11 = rotate; in_shamt MSB unused? no -- mode 11 = ROL by in_shamt;
//    ROR obtained by caller via shamt = WIDTH-n; out_illegal always 0.
//  Undefined: mode 11 yields out_data = in_data unshifted with out_illegal=1; latency/handshake unchanged.
// STRUCTURE
//  shifter_pkg: shift_mode_t enum {SH_SLL=2'b00, SH_SRL=2'b01, SH_SRA=2'b10, SH_ROT=2'b11};
//    function bit_reverse; localparam helper for levels-per-stage.
//  Sub-module shift_stage: combinational levels [LO..HI] of left shift with fill bit + rotate select;
//    instantiated PIPE_STAGES times by generate, each followed by valid/data/tag/mode register.
// TESTING (WIDTH=32, PIPE_STAGES=2, out_ready=1 unless stated)
//  SLL 0x0000_0001 shamt 31 tag 7 -> cycle+2: out_data 0x8000_0000, out_tag 7, out_illegal 0.
//  SRA 0x8000_00F0 shamt 4 -> 0xF800_000F; SRL same -> 0x0800_000F; shamt 0 any mode -> input unchanged.
//  Mode 11 on 0x8000_0001 shamt 1: with SHIFTER_ROTATE_EN -> 0x0000_0003; without -> 0x8000_0001, out_illegal 1.
//  Back-to-back 4 ops, out_ready low cycles 3-5: in_ready falls after pipe fills, results in order, none lost/duplicated.
//  flush asserted while 2 ops in flight plus in_valid -> no out_valid in following 3 cycles; next op latency 2.
//  Random 10k ops all modes/shamts vs reference model, random out_ready and flush; PIPE_STAGES=1 and 5 also run.

Source files
------------

// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// The optional rotate mode is selected at build time by SHIFTER_ROTATE_EN
// (see pipelined_barrel_shifter.sv); nothing in this package depends on it.
package shifter_pkg;

    typedef enum logic [1:0] {
        SH_SLL = 2'b00,
        SH_SRL = 2'b01,
        SH_SRA = 2'b10,
        SH_ROT = 2'b11
    } shift_mode_t;

    // Upper bound on WIDTH supported by bit_reverse (operand is zero-extended to this).
    localparam int MAX_WIDTH = 256;

    // Number of log-shift levels handled per pipeline stage; the last stage takes the remainder.
    function automatic int levels_per_stage(input int shamt_w, input int stages);
        return (shamt_w + stages - 1) / stages;
    endfunction

    // Reverses the low w bits of v; bits at and above w come back as zero.
    function automatic logic [MAX_WIDTH-1:0] bit_reverse(input logic [MAX_WIDTH-1:0] v, input int w);
        logic [MAX_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (i < w) r[w-1-i] = v[i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// Combinational slice of the log shifter: levels HI down to HI-NLEV+1.
// Each level shifts left by 2**level when its shamt bit is set, filling the
// vacated low bits either with the carried fill bit or, for rotate, with the
// bits shifted out the top. NLEV may be zero for a trailing stage with no levels.
module shift_stage #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5,
    parameter int HI      = 4,
    parameter int NLEV    = 1
) (
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic               fill,
    input  logic               rot,
    output logic [WIDTH-1:0]   data_out
);

    // Each stage only looks at its own shamt bits; the rest are intentionally ignored.
    logic unused_in;
    assign unused_in = ^{shamt, fill, rot};

    function automatic logic [WIDTH-1:0] level_shift(input logic [WIDTH-1:0] d, input int lvl,
                                                     input logic fill_bit, input logic rot_en);
        int               amt;
        logic [WIDTH-1:0] spill;
        amt = 1 << lvl;
        if (rot_en)        spill = d >> (WIDTH - amt);
        else if (fill_bit) spill = ~({WIDTH{1'b1}} << amt);
        else               spill = '0;
        return (d << amt) | spill;
    endfunction

    // Apply this stage's levels, largest shift first.
    always_comb begin
        data_out = data_in;
        for (int i = 0; i < NLEV; i++) begin
            if (shamt[HI-i]) data_out = level_shift(data_out, HI - i, fill, rot);
        end
    end

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined SLL/SRL/SRA/(ROL) shifter with valid/ready handshake, tag
// pass-through and flush. Right shifts reuse the left-shift network by
// bit-reversing the operand on entry and the result on exit.
// Build option: define SHIFTER_ROTATE_EN to make mode 11 a rotate-left;
// otherwise mode 11 passes the operand through and flags out_illegal.
module pipelined_barrel_shifter
    import shifter_pkg::*;
#(
    parameter int  WIDTH       = 32,
    parameter int  PIPE_STAGES = 2,
    parameter int  TAG_W       = 5,
    localparam int SHAMT_W     = $clog2(WIDTH)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_mode,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [TAG_W-1:0]   out_tag,
    output logic               out_illegal
);

    localparam int LPS  = levels_per_stage(SHAMT_W, PIPE_STAGES);
    localparam int LAST = PIPE_STAGES - 1;

    function automatic logic [WIDTH-1:0] rev_w(input logic [WIDTH-1:0] v);
        logic [MAX_WIDTH-1:0] wide;
        wide = bit_reverse({{(MAX_WIDTH-WIDTH){1'b0}}, v}, WIDTH);
        return wide[WIDTH-1:0];
    endfunction

    // Stage register contents (q_*) and the values offered to each stage (src_*).
    logic [PIPE_STAGES-1:0]              q_v, src_v, q_f, src_f;
    logic [PIPE_STAGES-1:0][WIDTH-1:0]   q_d, src_d, shf_d;
    logic [PIPE_STAGES-1:0][SHAMT_W-1:0] q_s, src_s;
    logic [PIPE_STAGES-1:0][TAG_W-1:0]   q_t, src_t;
    shift_mode_t [PIPE_STAGES-1:0]       q_m, src_m;
    logic [PIPE_STAGES:0]                rdy;

    // Entry conditioning: reverse for right shifts, capture sign fill, neutralise illegal mode.
    shift_mode_t        mode_in;
    logic               rev_in;
    logic [WIDTH-1:0]   pre_d;
    logic [SHAMT_W-1:0] pre_s;
    logic               pre_f;

    assign mode_in = shift_mode_t'(in_mode);
    assign rev_in  = (mode_in == SH_SRL) || (mode_in == SH_SRA);
    assign pre_d   = rev_in ? rev_w(in_data) : in_data;
    assign pre_f   = (mode_in == SH_SRA) && in_data[WIDTH-1];

`ifdef SHIFTER_ROTATE_EN
    assign pre_s       = in_shamt;
    assign out_illegal = 1'b0;
`else
    // Unsupported rotate travels with shamt forced to 0, so it emerges unshifted.
    assign pre_s       = (mode_in == SH_ROT) ? '0 : in_shamt;
    assign out_illegal = (q_m[LAST] == SH_ROT);
`endif

    // Ready ripples back from the consumer: a stage can load if empty or draining.
    always_comb begin
        rdy              = '0;
        rdy[PIPE_STAGES] = out_ready;
        for (int k = PIPE_STAGES - 1; k >= 0; k--) begin
            rdy[k] = !q_v[k] || rdy[k+1];
        end
    end

    assign in_ready = rdy[0];

    for (genvar k = 0; k < PIPE_STAGES; k++) begin : g_stage
        localparam int HI     = SHAMT_W - 1 - k * LPS;
        localparam int REMAIN = SHAMT_W - k * LPS;
        localparam int NLEV   = (REMAIN <= 0) ? 0 : ((REMAIN < LPS) ? REMAIN : LPS);

        logic               v_r, f_r;
        logic [WIDTH-1:0]   d_r;
        logic [SHAMT_W-1:0] s_r;
        logic [TAG_W-1:0]   t_r;
        shift_mode_t        m_r;

        if (k == 0) begin : g_src_in
            assign src_v[k] = in_valid;
            assign src_d[k] = pre_d;
            assign src_s[k] = pre_s;
            assign src_f[k] = pre_f;
            assign src_t[k] = in_tag;
            assign src_m[k] = mode_in;
        end else begin : g_src_prev
            assign src_v[k] = q_v[k-1];
            assign src_d[k] = q_d[k-1];
            assign src_s[k] = q_s[k-1];
            assign src_f[k] = q_f[k-1];
            assign src_t[k] = q_t[k-1];
            assign src_m[k] = q_m[k-1];
        end

        shift_stage #(
            .WIDTH   (WIDTH),
            .SHAMT_W (SHAMT_W),
            .HI      (HI),
            .NLEV    (NLEV)
        ) u_stage (
            .data_in  (src_d[k]),
            .shamt    (src_s[k]),
            .fill     (src_f[k]),
            .rot      (src_m[k] == SH_ROT),
            .data_out (shf_d[k])
        );

        // Stage register: valid obeys reset > flush > handshake; payload loads on transfer.
        always_ff @(posedge clock) begin
            if (reset) begin
                v_r <= 1'b0;
                d_r <= '0;
                s_r <= '0;
                f_r <= 1'b0;
                t_r <= '0;
                m_r <= SH_SLL;
            end else begin
                if (flush)       v_r <= 1'b0;
                else if (rdy[k]) v_r <= src_v[k];
                if (rdy[k] && src_v[k]) begin
                    d_r <= shf_d[k];
                    s_r <= src_s[k];
                    f_r <= src_f[k];
                    t_r <= src_t[k];
                    m_r <= src_m[k];
                end
            end
        end

        assign q_v[k] = v_r;
        assign q_d[k] = d_r;
        assign q_s[k] = s_r;
        assign q_f[k] = f_r;
        assign q_t[k] = t_r;
        assign q_m[k] = m_r;
    end

    // The final stage's shamt and fill have no further consumer.
    logic unused_tail;
    assign unused_tail = ^{q_s[LAST], q_f[LAST]};

    assign out_valid = q_v[LAST];
    assign out_tag   = q_t[LAST];
    assign out_data  = ((q_m[LAST] == SH_SRL) || (q_m[LAST] == SH_SRA)) ? rev_w(q_d[LAST]) : q_d[LAST];

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Self-checking bench for pipelined_barrel_shifter (WIDTH=32).
// Expected results come from a plain-arithmetic shift model and a queue scoreboard.
module tb_pipelined_barrel_shifter;

    localparam int W  = 32;
    localparam int SW = 5;
    localparam int TW = 5;
    localparam int P  = 2;
`ifdef SHIFTER_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [W-1:0]  in_data, out_data;
    logic [SW-1:0] in_shamt;
    logic [1:0]    in_mode;
    logic [TW-1:0] in_tag, out_tag;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    pipelined_barrel_shifter #(.WIDTH(W), .PIPE_STAGES(P), .TAG_W(TW)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_shamt    (in_shamt),
        .in_mode     (in_mode),
        .in_tag      (in_tag),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_tag     (out_tag),
        .out_illegal (out_illegal)
    );

    function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] m);
        case (m)
            2'b00:   return d << s;
            2'b01:   return d >> s;
            2'b10:   return $unsigned($signed(d) >>> s);
            default: begin
                if (!ROT_EN || s == 0) return d;
                return (d << s) | (d >> (W - int'(s)));
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, want);
        end
    endtask

    // Scoreboard of accepted operations, in issue order.
    typedef struct {
        logic [W-1:0]  data;
        logic [TW-1:0] tag;
        logic          ill;
    } exp_t;
    exp_t exp_q[$];
    exp_t e;
    bit   mon_en = 1'b0;
    int   n_out  = 0;
    logic stall_prev = 1'b0;
    logic [W-1:0]  held_d;
    logic [TW-1:0] held_t;
    logic          held_i;

    // Monitor: check outputs against the scoreboard, stall stability, and record accepts.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else if (mon_en) begin
            if (stall_prev) begin
                chk("stall_valid", 64'(out_valid), 64'(1));
                chk("stall_data", 64'(out_data), 64'(held_d));
                chk("stall_tag", 64'(out_tag), 64'(held_t));
                chk("stall_illegal", 64'(out_illegal), 64'(held_i));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_data", 64'(out_data), 64'(e.data));
                    chk("sb_tag", 64'(out_tag), 64'(e.tag));
                    chk("sb_illegal", 64'(out_illegal), 64'(e.ill));
                    n_out++;
                end
            end
            stall_prev = out_valid && !out_ready && !flush;
            held_d = out_data;
            held_t = out_tag;
            held_i = out_illegal;
            if (flush) exp_q.delete();
            else if (in_valid && in_ready)
                exp_q.push_back('{model(in_data, in_shamt, in_mode), in_tag, (in_mode == 2'b11) && !ROT_EN});
        end
    end

    // Present one op to an idle pipe; returns at posedge+1 just after the accepting edge.
    task automatic send(input logic [W-1:0] d, input logic [SW-1:0] s, input logic [1:0] m, input logic [TW-1:0] t);
        @(posedge clock); #1;
        in_valid = 1'b1; in_data = d; in_shamt = s; in_mode = m; in_tag = t;
        @(negedge clock);
        chk("accept_ready", 64'(in_ready), 64'(1));
        @(posedge clock); #1;
        in_valid = 1'b0;
    endtask

    // Count edges from acceptance until out_valid shows (bounded).
    task automatic wait_out(output int lat);
        lat = 1;
        @(negedge clock);
        while (!out_valid && lat < 12) begin
            @(posedge clock);
            lat++;
            @(negedge clock);
        end
    endtask

    typedef struct {
        logic [W-1:0]  d;
        logic [SW-1:0] s;
        logic [1:0]    m;
        logic [TW-1:0] t;
        logic [W-1:0]  exp_d;
        logic          exp_i;
    } vec_t;
    vec_t vecs[12];

    initial begin
        #2ms;
        $display("FAIL global_timeout: got time %0t expected finish", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int lat, base, idx;
        bit saw_block;

        vecs[0]  = '{32'h0000_0001, 5'd31, 2'b00, 5'd7,  32'h8000_0000, 1'b0};
        vecs[1]  = '{32'h8000_00F0, 5'd4,  2'b10, 5'd1,  32'hF800_000F, 1'b0};
        vecs[2]  = '{32'h8000_00F0, 5'd4,  2'b01, 5'd2,  32'h0800_000F, 1'b0};
        vecs[3]  = '{32'hDEAD_BEEF, 5'd0,  2'b00, 5'd3,  32'hDEAD_BEEF, 1'b0};
        vecs[4]  = '{32'hDEAD_BEEF, 5'd0,  2'b01, 5'd4,  32'hDEAD_BEEF, 1'b0};
        vecs[5]  = '{32'hDEAD_BEEF, 5'd0,  2'b10, 5'd5,  32'hDEAD_BEEF, 1'b0};
        vecs[6]  = '{32'h8000_0001, 5'd1,  2'b11, 5'd6,  ROT_EN ? 32'h0000_0003 : 32'h8000_0001, !ROT_EN};
        vecs[7]  = '{32'h1234_5678, 5'd0,  2'b11, 5'd8,  32'h1234_5678, !ROT_EN};
        vecs[8]  = '{32'h7FFF_FFFF, 5'd31, 2'b10, 5'd9,  32'h0000_0000, 1'b0};
        vecs[9]  = '{32'h8000_0000, 5'd31, 2'b10, 5'd10, 32'hFFFF_FFFF, 1'b0};
        vecs[10] = '{32'h8000_0000, 5'd31, 2'b01, 5'd11, 32'h0000_0001, 1'b0};
        vecs[11] = '{32'hFFFF_FFFF, 5'd16, 2'b00, 5'd31, 32'hFFFF_0000, 1'b0};

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_data = '0; in_shamt = '0; in_mode = '0; in_tag = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        chk("reset_in_ready", 64'(in_ready), 64'(1));
        chk("reset_out_valid", 64'(out_valid), 64'(0));
        chk("reset_out_data", 64'(out_data), 64'(0));
        chk("reset_out_tag", 64'(out_tag), 64'(0));
        chk("reset_out_illegal", 64'(out_illegal), 64'(0));

        // Table-driven directed vectors, one at a time into an idle pipe.
        foreach (vecs[i]) begin
            send(vecs[i].d, vecs[i].s, vecs[i].m, vecs[i].t);
            wait_out(lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(P));
            chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].exp_d));
            chk($sformatf("vec%0d_tag", i), 64'(out_tag), 64'(vecs[i].t));
            chk($sformatf("vec%0d_illegal", i), 64'(out_illegal), 64'(vecs[i].exp_i));
            @(posedge clock); #1;
        end
        @(negedge clock);
        chk("idle_out_valid", 64'(out_valid), 64'(0));

        // Back-to-back four ops with out_ready low in cycles 3..5.
        mon_en = 1'b1;
        base = n_out; idx = 0; saw_block = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(posedge clock); #1;
            out_ready = !(c >= 3 && c <= 5);
            if (idx < 4) begin
                in_valid = 1'b1;
                in_data  = 32'hA5A5_0000 + 32'(idx * 32'h1111);
                in_shamt = 5'(idx * 3 + 1);
                in_mode  = 2'(idx);
                in_tag   = 5'(idx + 20);
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clock);
            if (!in_ready) saw_block = 1'b1;
            if (in_valid && in_ready) idx++;
        end
        chk("bp_in_ready_fell", 64'(saw_block), 64'(1));
        chk("bp_all_accepted", 64'(idx), 64'(4));
        chk("bp_all_delivered", 64'(n_out - base), 64'(4));

        // Flush with two ops in flight plus a new offer.
        @(posedge clock); #1;
        out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0000_00FF; in_shamt = 5'd8; in_mode = 2'b00; in_tag = 5'd12;
        @(posedge clock); #1;
        in_data = 32'hF000_0000; in_shamt = 5'd2; in_mode = 2'b10; in_tag = 5'd13;
        @(posedge clock); #1;
        in_data = 32'h1111_1111; in_shamt = 5'd3; in_mode = 2'b01; in_tag = 5'd14; flush = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0; flush = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            chk($sformatf("flush_quiet_c%0d", c), 64'(out_valid), 64'(0));
            @(posedge clock); #1;
        end
        send(32'h0000_0F0F, 5'd4, 2'b00, 5'd15);
        wait_out(lat);
        chk("post_flush_latency", 64'(lat), 64'(P));
        chk("post_flush_data", 64'(out_data), 64'(32'h0000_F0F0));
        @(posedge clock); #1;

        // Reset while an op is in flight: nothing may emerge.
        out_ready = 1'b0;
        send(32'h0000_0001, 5'd1, 2'b00, 5'd9);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < P + 2; c++) begin
            @(negedge clock);
            chk($sformatf("reset_mid_quiet_c%0d", c), 64'(out_valid), 64'(0));
            @(posedge clock); #1;
        end

        // Randomised traffic against the scoreboard.
        base = n_out;
        for (int c = 0; c < 14000; c++) begin
            @(posedge clock); #1;
            in_valid  = ($urandom_range(0, 9) < 7);
            in_data   = $urandom;
            in_shamt  = 5'($urandom_range(0, 31));
            in_mode   = 2'($urandom_range(0, 3));
            in_tag    = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 49) == 0);
        end
        @(posedge clock); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) @(posedge clock);
        @(negedge clock);
        chk("drain_empty", 64'(exp_q.size()), 64'(0));
        chk("random_traffic_flowed", 64'(n_out - base > 2000), 64'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
